// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one synchronous memory port between the CPU core and a host
// loader/debug port. Round-robin arbitration, with an optional host burst
// lock that is capped so a waiting CPU is always served. Read data comes
// back one cycle after the grant, straight from the memory macro.
module mem_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 15,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    // CPU core requester
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_adr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    // host loader/debug requester
    input  logic          host_req,
    input  logic          host_we,
    input  logic          host_lock,
    input  logic [AW-1:0] host_adr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    // memory macro port
    output logic          mem_en,
    output logic          mem_we,
    output logic [1:0]    mem_wmask,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {
        OWN_CPU  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // Burst counter is 4 bits and saturates at 15; the lock limit is
    // expressed in the same width to keep the compare clean.
    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
    localparam logic [3:0] BURST_SAT = 4'hF;

    owner_t      owner_q, owner_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic [1:0]  rd_pend_q, rd_pend_d;   // {cpu_read_issued, host_read_issued}

    logic        cpu_sel;
    logic        host_sel;

    // Arbitration: lone requester wins; on a tie the host keeps a locked
    // burst until the limit, otherwise the non-owner goes next.
    always_comb begin
        cpu_sel  = 1'b0;
        host_sel = 1'b0;
        if (cpu_req && host_req) begin
            if (owner_q == OWN_HOST && host_lock && (burst_cnt_q < BURST_LIM)) begin
                host_sel = 1'b1;
            end else if (owner_q == OWN_HOST) begin
                cpu_sel = 1'b1;
            end else begin
                host_sel = 1'b1;
            end
        end else begin
            cpu_sel  = cpu_req;
            host_sel = host_req;
        end
    end

    // Grants are forced low while reset is held, even if requests are up.
    always_comb begin
        cpu_gnt  = cpu_sel & reset_n;
        host_gnt = host_sel & reset_n;
    end

    // Memory command built from whichever requester holds the grant.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_wmask = 2'b00;
        mem_adr   = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_en  = 1'b1;
            mem_we  = cpu_we;
            mem_adr = cpu_adr;
            if (cpu_we) begin
                // CPU only ever writes the low byte.
                mem_wmask = 2'b01;
                mem_wdata = {{(DW-8){1'b0}}, cpu_wdata};
            end
        end else if (host_gnt) begin
            mem_en  = 1'b1;
            mem_we  = host_we;
            mem_adr = host_adr;
            if (host_we) begin
                mem_wmask = 2'b11;
                mem_wdata = host_wdata;
            end
        end
    end

    // Next-state: ownership follows grants, burst count only survives
    // consecutive locked host grants, read tags follow issued reads.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = 4'd0;
        rd_pend_d   = {cpu_gnt & ~cpu_we, host_gnt & ~host_we};
        if (cpu_gnt) begin
            owner_d = OWN_CPU;
        end else if (host_gnt) begin
            owner_d = OWN_HOST;
        end
        if (host_gnt && host_lock) begin
            burst_cnt_d = (burst_cnt_q == BURST_SAT) ? BURST_SAT : burst_cnt_q + 4'd1;
        end
    end

    // State registers; reset leaves the host as owner so the CPU wins the
    // first tie, and drops any read still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q     <= OWN_HOST;
            burst_cnt_q <= 4'd0;
            rd_pend_q   <= 2'b00;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    // Read return: memory data is shared, the strobes say whose it is.
    always_comb begin
        cpu_rvalid  = rd_pend_q[1];
        host_rvalid = rd_pend_q[0];
        cpu_rdata   = mem_rdata;
        host_rdata  = mem_rdata;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives both requesters from transaction queues, models the synchronous
// memory macro, and checks every memory command and read response against
// a queue of hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int AW        = 8;
    localparam int DW        = 15;
    localparam int BURST_MAX = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_adr;
    logic [7:0]    cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
    logic [AW-1:0] host_adr;
    logic [DW-1:0] host_wdata, host_rdata;
    logic          mem_en, mem_we;
    logic [1:0]    mem_wmask;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we), .host_lock(host_lock), .host_adr(host_adr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wmask(mem_wmask), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- memory macro model ----------------
    // Unwritten words read as {7'h40, address}.
    logic [14:0] mem [0:255];
    bit          written [0:255];

    function automatic logic [14:0] mem_val(input logic [7:0] a);
        return written[a] ? mem[a] : (15'h4000 | {7'b0, a});
    endfunction

    function automatic logic [14:0] merge(input logic [14:0] old, input logic [14:0] wd, input logic [1:0] m);
        logic [14:0] v;
        v = old;
        if (m[0]) v[7:0]  = wd[7:0];
        if (m[1]) v[14:8] = wd[14:8];
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_adr]     <= merge(mem_val(mem_adr), mem_wdata, mem_wmask);
                written[mem_adr] <= 1'b1;
            end else begin
                mem_rdata <= mem_val(mem_adr);
            end
        end
    end

    // ---------------- stimulus queues and drivers ----------------
    typedef struct {
        bit          we;
        bit          lock;
        logic [7:0]  adr;
        logic [14:0] wdata;
    } txn_t;

    txn_t cpu_q[$];
    txn_t host_q[$];

    function automatic void cpu_issue(input bit we, input logic [7:0] adr, input logic [7:0] wd);
        txn_t t;
        t.we = we; t.lock = 1'b0; t.adr = adr; t.wdata = {7'b0, wd};
        cpu_q.push_back(t);
    endfunction

    function automatic void host_issue(input bit we, input bit lock, input logic [7:0] adr, input logic [14:0] wd);
        txn_t t;
        t.we = we; t.lock = lock; t.adr = adr; t.wdata = wd;
        host_q.push_back(t);
    endfunction

    // CPU driver: hold request until granted, then present the next one.
    initial begin
        bit   g;
        txn_t t;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        forever begin
            @(negedge clk); g = cpu_gnt;
            @(posedge clk); #1;
            if (cpu_req && g) cpu_req = 1'b0;
            if (!cpu_req && cpu_q.size() > 0) begin
                t = cpu_q.pop_front();
                cpu_we = t.we; cpu_adr = t.adr; cpu_wdata = t.wdata[7:0]; cpu_req = 1'b1;
            end
        end
    end

    // Host driver: same handshake, lock travels with each transaction.
    initial begin
        bit   g;
        txn_t t;
        host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0; host_adr = '0; host_wdata = '0;
        forever begin
            @(negedge clk); g = host_gnt;
            @(posedge clk); #1;
            if (host_req && g) begin
                host_req  = 1'b0;
                host_lock = 1'b0;
            end
            if (!host_req && host_q.size() > 0) begin
                t = host_q.pop_front();
                host_we = t.we; host_lock = t.lock; host_adr = t.adr; host_wdata = t.wdata; host_req = 1'b1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          host;
        logic [7:0]  adr;
        bit          we;
        logic [1:0]  wmask;
        logic [14:0] wdata;
        logic [14:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    function automatic void expect_cmd(input bit host, input logic [7:0] adr, input bit we,
                                       input logic [1:0] wmask, input logic [14:0] wdata,
                                       input logic [14:0] rdata);
        exp_t e;
        e.host = host; e.adr = adr; e.we = we; e.wmask = wmask; e.wdata = wdata; e.rdata = rdata;
        exp_q.push_back(e);
    endfunction

    bit          cpu_due, host_due;
    logic [14:0] cpu_due_data, host_due_data;

    // Monitor: compares at the falling edge, away from the active edge.
    initial begin
        exp_t e;
        bit   ok;
        cpu_due = 1'b0; host_due = 1'b0;
        cpu_due_data = '0; host_due_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cpu_due  = 1'b0;
                host_due = 1'b0;
                vectors++;
                if (cpu_gnt || host_gnt || mem_en || mem_we || cpu_rvalid || host_rvalid ||
                    mem_wmask != 2'b00 || mem_adr != '0 || mem_wdata != '0) begin
                    miscompares++;
                    $display("FAIL reset_outputs: got gnt=%b%b en=%b we=%b rv=%b%b wmask=%b adr=%h wdata=%h, required all 0",
                             cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid, host_rvalid, mem_wmask, mem_adr, mem_wdata);
                end
            end else begin
                if (cpu_rvalid || cpu_due) begin
                    vectors++;
                    if (!(cpu_rvalid && cpu_due && cpu_rdata == cpu_due_data)) begin
                        miscompares++;
                        $display("FAIL cpu_rsp: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                                 cpu_rvalid, cpu_rdata, cpu_due, cpu_due_data);
                    end
                end
                if (host_rvalid || host_due) begin
                    vectors++;
                    if (!(host_rvalid && host_due && host_rdata == host_due_data)) begin
                        miscompares++;
                        $display("FAIL host_rsp: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                                 host_rvalid, host_rdata, host_due, host_due_data);
                    end
                end
                cpu_due  = 1'b0;
                host_due = 1'b0;

                if (cpu_req || host_req) begin
                    vectors++;
                    if (!mem_en) begin
                        miscompares++;
                        $display("FAIL stall: got mem_en=0 with req=%b%b, required mem_en=1", cpu_req, host_req);
                    end
                end

                if (mem_en || cpu_gnt || host_gnt) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL cmd_extra: got gnt=%b%b adr=%h we=%b, required no access",
                                 cpu_gnt, host_gnt, mem_adr, mem_we);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (cpu_gnt == !e.host) && (host_gnt == e.host) && mem_en &&
                             (mem_adr == e.adr) && (mem_we == e.we) && (mem_wmask == e.wmask) &&
                             (!e.we || mem_wdata == e.wdata);
                        if (!ok) begin
                            miscompares++;
                            $display("FAIL cmd: got gnt(c,h)=%b%b en=%b adr=%h we=%b wmask=%b wdata=%h, required gnt(c,h)=%b%b en=1 adr=%h we=%b wmask=%b wdata=%h",
                                     cpu_gnt, host_gnt, mem_en, mem_adr, mem_we, mem_wmask, mem_wdata,
                                     !e.host, e.host, e.adr, e.we, e.wmask, e.wdata);
                        end else begin
                            $display("cmd %s adr=%h we=%b wmask=%b", e.host ? "host" : "cpu ", mem_adr, mem_we, mem_wmask);
                            if (!e.we) begin
                                if (e.host) begin host_due = 1'b1; host_due_data = e.rdata; end
                                else        begin cpu_due  = 1'b1; cpu_due_data  = e.rdata; end
                            end
                        end
                    end
                end
            end
        end
    end

    // Wait until all issued traffic has been granted and answered.
    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (cpu_q.size() == 0 && host_q.size() == 0 && !cpu_req && !host_req && exp_q.size() == 0)
                done = 1'b1;
        end
        repeat (2) @(negedge clk);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d commands outstanding, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            vectors++;
            if (mem_en || cpu_gnt || host_gnt) begin
                miscompares++;
                $display("FAIL idle: got en=%b gnt=%b%b, required 0", mem_en, cpu_gnt, host_gnt);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        reset_n = 1'b0;

        // First tie after reset: both reads queued while reset is held.
        cpu_issue(1'b0, 8'h10, 8'h00);
        host_issue(1'b0, 1'b0, 8'h20, 15'h0);
        expect_cmd(1'b0, 8'h10, 1'b0, 2'b00, 15'h0, 15'h4010);
        expect_cmd(1'b1, 8'h20, 1'b0, 2'b00, 15'h0, 15'h4020);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        drain("tie");

        // Write masks, then read back to confirm only the masked lanes moved.
        cpu_issue(1'b1, 8'h03, 8'hA5);
        host_issue(1'b1, 1'b0, 8'h04, 15'h7FFF);
        expect_cmd(1'b0, 8'h03, 1'b1, 2'b01, 15'h00A5, 15'h0);
        expect_cmd(1'b1, 8'h04, 1'b1, 2'b11, 15'h7FFF, 15'h0);
        drain("wmask");
        cpu_issue(1'b0, 8'h03, 8'h00);
        host_issue(1'b0, 1'b0, 8'h04, 15'h0);
        expect_cmd(1'b0, 8'h03, 1'b0, 2'b00, 15'h0, 15'h40A5);
        expect_cmd(1'b1, 8'h04, 1'b0, 2'b00, 15'h0, 15'h7FFF);
        drain("readback");

        // Locked host burst against a waiting CPU: 4 host, 1 CPU, 4 host, 1 CPU, 1 host.
        for (int i = 0; i < 9; i++) host_issue(1'b0, 1'b1, 8'h30 + 8'(i), 15'h0);
        cpu_issue(1'b0, 8'h40, 8'h00);
        cpu_issue(1'b0, 8'h41, 8'h00);
        for (int i = 0; i < 4; i++) expect_cmd(1'b1, 8'h30 + 8'(i), 1'b0, 2'b00, 15'h0, 15'h4030 + 15'(i));
        expect_cmd(1'b0, 8'h40, 1'b0, 2'b00, 15'h0, 15'h4040);
        for (int i = 4; i < 8; i++) expect_cmd(1'b1, 8'h30 + 8'(i), 1'b0, 2'b00, 15'h0, 15'h4030 + 15'(i));
        expect_cmd(1'b0, 8'h41, 1'b0, 2'b00, 15'h0, 15'h4041);
        expect_cmd(1'b1, 8'h38, 1'b0, 2'b00, 15'h0, 15'h4038);
        drain("burst");

        // Unlocked fairness: owner is host, so strict C,H,C,H,... alternation.
        for (int i = 0; i < 5; i++) begin
            cpu_issue(1'b0, 8'h50 + 8'(i), 8'h00);
            host_issue(1'b0, 1'b0, 8'h60 + 8'(i), 15'h0);
            expect_cmd(1'b0, 8'h50 + 8'(i), 1'b0, 2'b00, 15'h0, 15'h4050 + 15'(i));
            expect_cmd(1'b1, 8'h60 + 8'(i), 1'b0, 2'b00, 15'h0, 15'h4060 + 15'(i));
        end
        drain("fair");

        // Build up burst count 3, go idle, then a locked burst must get a full 4 slots.
        for (int i = 0; i < 3; i++) begin
            host_issue(1'b0, 1'b1, 8'h70 + 8'(i), 15'h0);
            expect_cmd(1'b1, 8'h70 + 8'(i), 1'b0, 2'b00, 15'h0, 15'h4070 + 15'(i));
        end
        drain("preidle");
        idle_check(5);
        for (int i = 0; i < 5; i++) host_issue(1'b0, 1'b1, 8'h80 + 8'(i), 15'h0);
        cpu_issue(1'b0, 8'h90, 8'h00);
        for (int i = 0; i < 4; i++) expect_cmd(1'b1, 8'h80 + 8'(i), 1'b0, 2'b00, 15'h0, 15'h4080 + 15'(i));
        expect_cmd(1'b0, 8'h90, 1'b0, 2'b00, 15'h0, 15'h4090);
        expect_cmd(1'b1, 8'h84, 1'b0, 2'b00, 15'h0, 15'h4084);
        drain("idle_burst");

        // Idle must not change owner (host): an unlocked tie goes to the CPU.
        idle_check(5);
        cpu_issue(1'b0, 8'h91, 8'h00);
        host_issue(1'b0, 1'b0, 8'h85, 15'h0);
        expect_cmd(1'b0, 8'h91, 1'b0, 2'b00, 15'h0, 15'h4091);
        expect_cmd(1'b1, 8'h85, 1'b0, 2'b00, 15'h0, 15'h4085);
        drain("idle_owner");

        // Reset during an outstanding host read: response is dropped.
        host_issue(1'b0, 1'b0, 8'hA0, 15'h0);
        expect_cmd(1'b1, 8'hA0, 1'b0, 2'b00, 15'h0, 15'h40A0);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (host_gnt) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midrd_gnt: got host_gnt=0 within 20 cycles, required 1");
            exp_q.delete();
        end
        cpu_issue(1'b0, 8'hA1, 8'h00);
        expect_cmd(1'b0, 8'hA1, 1'b0, 2'b00, 15'h0, 15'h40A1);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (host_rvalid || cpu_rvalid || mem_en) begin
            miscompares++;
            $display("FAIL midrd_async: got rv=%b%b en=%b right after reset, required 0", cpu_rvalid, host_rvalid, mem_en);
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        drain("midrd");

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d expected commands unserved, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the processor's single external instruction/data memory port between two requesters: the CPU core and a host loader/debug port.
- The host port loads programs and inspects memory while the core runs.
- Arbitration is round-robin. A host burst-lock mode is bounded by a starvation limit, so the core always makes forward progress.
- Read data returns one cycle after grant, matching the synchronous memory macro.

Parameters:
- AW, 8, address width (256-word space).
- DW, 15, memory word width: bits [14:8] are the high field, [7:0] the low byte.
- BURST_MAX, 4, max consecutive locked host grants while cpu_req is pending (range 1..15).

Ports:
- clk  input  1  single system clock, rising edge
- reset_n  input  1  async reset, active-low
- cpu_req  input  1  core requests an access; held until cpu_gnt
- cpu_we  input  1  1=write low byte, 0=read word
- cpu_adr  input  AW  core address
- cpu_wdata  input  8  core write byte
- cpu_gnt  output  1  core access issued this cycle
- cpu_rvalid  output  1  core read data valid
- cpu_rdata  output  DW  core read data
- host_req  input  1  host requests an access; held until host_gnt
- host_we  input  1  1=write full word, 0=read
- host_lock  input  1  host asks to keep ownership for back-to-back accesses
- host_adr  input  AW  host address
- host_wdata  input  DW  host write word
- host_gnt  output  1  host access issued this cycle
- host_rvalid  output  1  host read data valid
- host_rdata  output  DW  host read data
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write
- mem_wmask  output  2  bit0 enables [7:0], bit1 enables [14:8]
- mem_adr  output  AW  memory address
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. Clock port clk, reset port reset_n.
- Registered state:
  - owner ∈ {OWN_CPU, OWN_HOST}: last granted requester.
  - burst_cnt, 4 bits: consecutive host grants.
  - rd_pend, 2 bits: {cpu_read_issued, host_read_issued}.
- Reset values: owner=OWN_HOST (CPU wins the first tie), burst_cnt=0, rd_pend=0.
- Reset behaviour:
  - While reset_n=0: cpu_gnt, host_gnt, mem_en, mem_we, cpu_rvalid and host_rvalid are all 0.
  - mem_wmask=0; mem_adr and mem_wdata=0.
  - A reset asserted mid-read drops the pending response; no rvalid follows after reset release.
- Grant (combinational from requests and registered state; at most one grant per cycle):
  - Only one requester active: it is granted.
  - Both active, owner=OWN_HOST, host_lock=1, burst_cnt<BURST_MAX: host granted.
  - Both active, otherwise: the requester that is not owner is granted (round-robin).
  - No requests: no grant, mem_en=0, state unchanged except burst_cnt.
- Memory command (combinational from the granted requester):
  - mem_en=cpu_gnt|host_gnt; mem_adr and mem_we come from the granted requester.
  - CPU write: mem_wdata={7'b0,cpu_wdata}, mem_wmask=2'b01.
  - Host write: mem_wdata=host_wdata, mem_wmask=2'b11.
  - Reads: mem_wmask=2'b00.
- State update at posedge clk:
  - owner becomes the granted requester when a grant occurs.
  - burst_cnt=min(burst_cnt+1,15) on host_gnt & host_lock; otherwise cleared to 0, including on any cpu_gnt or idle cycle.
- Read return:
  - rd_pend captures {cpu_gnt&~cpu_we, host_gnt&~host_we}.
  - cpu_rvalid=rd_pend[1], host_rvalid=rd_pend[0], each exactly one cycle after the grant.
  - cpu_rdata and host_rdata both pass mem_rdata through; only the rvalid strobes qualify them.
  - Back-to-back reads give rvalid on consecutive cycles. Alternating owners give alternating rvalids with no gaps.
- Writes produce no response. A write is complete when its grant is seen.
- Requester rules: adr, we and wdata are stable while req=1 and gnt=0. A requester deasserts req, or presents its next request, the cycle after gnt.
- Starvation bound: with cpu_req held, the CPU is granted within BURST_MAX+1 cycles.
- Without host_lock, the host is granted within 2 cycles.

Test Plan:
- Reset/first tie: after reset release, assert cpu_req read adr 0x10 and host_req read adr 0x20 in the same cycle -> cpu_gnt=1, mem_adr=0x10 first; host_gnt next cycle with mem_adr=0x20; cpu_rvalid then host_rvalid on consecutive cycles with the preloaded words.
- Write masks: CPU write 0xA5 to adr 0x03, then host write 0x7FFF to 0x04 -> mem_wmask 01 then 11, mem_wdata 0x00A5 then 0x7FFF; neither requester sees rvalid.
- Locked burst: host_lock=1, host reads 8 consecutive addresses while cpu_req is held from cycle 0 (BURST_MAX=4) -> host granted 4 cycles, CPU 1 cycle, host 4 cycles; burst_cnt returns to 0 after the CPU slot.
- Unlocked fairness: both requesters continuously request with host_lock=0 -> grants strictly alternate CPU/host over 10 cycles.
- Reset mid-read: host read granted, reset_n pulled low before the next edge -> host_rvalid never asserts; all grants and mem_en stay 0 while reset_n=0.
- Idle: no requests for 5 cycles -> mem_en=0, burst_cnt=0, owner unchanged.
